fetch_stage: RTL

//  Instruction-fetch stage and IF/DE pipeline register, directly upstream of decode and of the load-use hazard unit.

---
 rtl/pipeline_pkg.sv | 19 +
 rtl/fetch_skid_buf.sv | 33 +++
 rtl/fetch_stage.sv | 102 ++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the fetch stage and its IF/DE pipeline register.
package pipeline_pkg;
  localparam int          XLEN         = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic            valid;
  } if_de_t;

  // INFLIGHT: a response arrives this cycle; HELD: the response sits in the skid buffer.
  typedef enum logic [1:0] {
    FS_IDLE     = 2'd0,
    FS_INFLIGHT = 2'd1,
    FS_HELD     = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register that parks an in-flight fetch response while decode is stalled.
module fetch_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic         capture_i,
  input  logic         release_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         vld_o
);
  logic [W-1:0] data_q;
  logic         vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else if (clear_i) begin
      vld_q  <= 1'b0;
    end else if (capture_i) begin
      data_q <= data_i;
      vld_q  <= 1'b1;
    end else if (release_i) begin
      vld_q  <= 1'b0;
    end
  end

  assign data_o = data_q;
  assign vld_o  = vld_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives a 1-cycle synchronous imem and loads the IF/DE register,
// honouring load-use stalls (via a skid buffer) and EX branch redirects (flush).
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            HDUStall,
  input  logic            br_taken_ex,
  input  logic [XLEN-1:0] br_target_ex,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_rd_en,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     inst_de,
  output logic [XLEN-1:0] pc_de,
  output logic [XLEN-1:0] pc4_de,
  output logic            valid_de,
  output logic [4:0]      rs1_de,
  output logic [4:0]      rs2_de
);
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_f_q, pc_f_d;
  logic [XLEN-1:0] pc_req_q, pc_req_d;
  if_de_t          de_q, de_d;
  if_de_t          resp, skid_data;
  logic            skid_vld;
  logic            flush, stall, issue, capture;

  // Flush wins over stall; a redirect never issues in the same cycle.
  assign flush   = br_taken_ex;
  assign stall   = HDUStall && !br_taken_ex;
  assign issue   = !HDUStall && !br_taken_ex;
  assign capture = stall && (state_q == FS_INFLIGHT);
  assign resp    = '{inst: imem_rdata, pc: pc_req_q, valid: 1'b1};

  fetch_skid_buf #(.W($bits(if_de_t))) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (flush),
    .capture_i (capture),
    .release_i (issue),
    .data_i    (resp),
    .data_o    (skid_data),
    .vld_o     (skid_vld)
  );

  always_comb begin
    state_d  = FS_IDLE;
    pc_f_d   = pc_f_q;
    pc_req_d = pc_req_q;
    de_d     = de_q;
    if (issue) begin
      state_d  = FS_INFLIGHT;
      pc_f_d   = pc_f_q + XLEN'(4);
      pc_req_d = pc_f_q;
    end else if (stall && (state_q == FS_INFLIGHT || state_q == FS_HELD)) begin
      state_d = FS_HELD;
    end
    if (flush) begin
      pc_f_d = br_target_ex & ALIGN_MASK;
      de_d   = '{inst: NOP_INST, pc: de_q.pc, valid: 1'b0};
    end else if (!stall) begin
      case (state_q)
        FS_HELD:     de_d = skid_data;
        FS_INFLIGHT: de_d = resp;
        default:     de_d = '{inst: NOP_INST, pc: de_q.pc, valid: 1'b0};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FS_IDLE;
      pc_f_q   <= RESET_PC;
      pc_req_q <= '0;
      de_q     <= '{inst: NOP_INST, pc: '0, valid: 1'b0};
    end else begin
      state_q  <= state_d;
      pc_f_q   <= pc_f_d;
      pc_req_q <= pc_req_d;
      de_q     <= de_d;
    end
  end

  assign imem_addr  = pc_f_q;
  assign imem_rd_en = issue;
  assign inst_de    = de_q.inst;
  assign pc_de      = de_q.pc;
  assign valid_de   = de_q.valid;
  assign pc4_de     = de_q.pc + XLEN'(4);
  assign rs1_de     = de_q.valid ? de_q.inst[19:15] : 5'd0;
  assign rs2_de     = de_q.valid ? de_q.inst[24:20] : 5'd0;

  // Sanity: the skid buffer flag and the HELD state describe the same condition.
  always_ff @(posedge clk) begin
    if (rst_n) assert ((state_q == FS_HELD) == skid_vld);
  end
endmodule
